// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM slave between NM masters; the grant is held for the whole cyc.
// Define WB_ARB_WATCHDOG_EN to add a hung-slave watchdog that errors the owner after TIMEOUT stalled cycles.
module wb_mem_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [NM*AW-1:0]      m_adr_i,
  input  logic [NM*DW-1:0]      m_dat_i,
  input  logic [NM*(DW/8)-1:0]  m_sel_i,
  input  logic [NM-1:0]         m_we_i,
  input  logic [NM-1:0]         m_cyc_i,
  input  logic [NM-1:0]         m_stb_i,
  input  logic [NM*3-1:0]       m_cti_i,
  input  logic [NM*2-1:0]       m_bte_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NM-1:0]         m_ack_o,
  output logic [NM-1:0]         m_err_o,
  output logic [NM-1:0]         m_rty_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  output logic [NM-1:0]         grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NM);

`ifdef WB_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WDOG} state_e;
  localparam int CW = 16;
  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          any_rsp, wdog_fire;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY} state_e;
`endif

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NM-1:0] pick;
  logic [IW-1:0] g_idx, rr_next;
  logic          own_cyc, own_stb;

  assign own_cyc = |(m_cyc_i & grant_q);
  assign own_stb = |(m_stb_i & grant_q);
  assign rr_next = (g_idx == IW'(NM - 1)) ? '0 : g_idx + 1'b1;
  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) g_idx = IW'(i);
    end
  end

  // Search starts at rr_ptr and wraps, so the first requester in rotation order wins.
  always_comb begin : arb
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NM) idx = idx - NM;
      if (!found && m_cyc_i[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*SW +: SW];
        s_we_o  = m_we_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
      end
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  assign any_rsp   = s_ack_i | s_err_i | s_rty_i;
  assign wdog_fire = (state_q == ST_BUSY) && own_cyc && own_stb && !any_rsp &&
                     (wdog_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    if (state_q != ST_BUSY || any_rsp) wdog_cnt_d = '0;
    else if (own_stb)                  wdog_cnt_d = wdog_cnt_q + 1'b1;
    else                               wdog_cnt_d = wdog_cnt_q;
  end
`endif

  // NOTE: every output and next-state value gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        // Responses are suppressed while reset is asserted so an in-flight ack never reaches a master.
        m_ack_o = grant_q & {NM{s_ack_i & wb_rst_ni}};
        m_err_o = grant_q & {NM{s_err_i & wb_rst_ni}};
        m_rty_o = grant_q & {NM{s_rty_i & wb_rst_ni}};
        if (!own_cyc) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
`ifdef WB_ARB_WATCHDOG_EN
        else if (wdog_fire) begin
          m_err_o = grant_q & {NM{wb_rst_ni}};
          state_d = ST_WDOG;
        end
      end
      ST_WDOG: begin
        if (!own_cyc) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef WB_ARB_WATCHDOG_EN
      wdog_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef WB_ARB_WATCHDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
`endif
    end
  end

endmodule
